// File: rtl/simple_gemac_rx_buffer.sv
// Receive frame buffer behind the GEMAC receiver: bytes are stored speculatively,
// good frames are committed through a length FIFO and replayed as a framed byte stream.
module simple_gemac_rx_buffer #(
    parameter int AWIDTH = 11,
    parameter int LWIDTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_error,
    input  logic        rx_ack,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_src_rdy,
    input  logic        out_dst_rdy,
    output logic [15:0] frames_rcvd,
    output logic [15:0] frames_dropped,
    output logic        overrun
);
    localparam int DEPTH  = 1 << AWIDTH;
    localparam int LDEPTH = 1 << LWIDTH;

    typedef logic [AWIDTH:0] ptr_t;
    typedef logic [LWIDTH:0] lptr_t;
    typedef enum logic {IDLE, STREAM} rd_state_t;

    logic [7:0]  data_ram [DEPTH];
    logic [15:0] len_ram  [LDEPTH];

    ptr_t        wr_ptr, commit_ptr, rd_ptr, rd_next;
    lptr_t       lf_wr, lf_rd;
    logic [15:0] cur_len, rd_left;
    logic        drop;
    rd_state_t   state;

    logic buf_full, lf_full, lf_empty;
    logic byte_in, do_write, do_commit, do_reject, set_drop;

    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        buf_full  = (wr_ptr - rd_ptr) == ptr_t'(DEPTH);
        lf_full   = (lf_wr - lf_rd) == lptr_t'(LDEPTH);
        lf_empty  = lf_wr == lf_rd;
        do_commit = !rx_error && rx_ack && !drop && !lf_full && cur_len != 16'd0;
        do_reject = !rx_error && rx_ack && (drop || lf_full);
        byte_in   = !rx_error && !rx_ack && rx_valid && !drop;
        do_write  = byte_in && !buf_full && cur_len != 16'hFFFF;
        set_drop  = byte_in && !do_write;
        rd_next   = rd_ptr + ptr_t'(1);
    end

    // NOTE: the storage arrays have no reset; pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_write)
            data_ram[wr_ptr[AWIDTH-1:0]] <= rx_data;
        if (do_commit)
            len_ram[lf_wr[LWIDTH-1:0]] <= cur_len;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            commit_ptr     <= '0;
            lf_wr          <= '0;
            cur_len        <= '0;
            drop           <= 1'b0;
            frames_rcvd    <= '0;
            frames_dropped <= '0;
            overrun        <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (rx_error) begin
                wr_ptr  <= commit_ptr;
                cur_len <= '0;
                drop    <= 1'b0;
            end else if (do_commit) begin
                commit_ptr <= wr_ptr;
                lf_wr      <= lf_wr + lptr_t'(1);
                cur_len    <= '0;
                if (frames_rcvd != 16'hFFFF)
                    frames_rcvd <= frames_rcvd + 16'd1;
            end else if (do_reject) begin
                wr_ptr  <= commit_ptr;
                cur_len <= '0;
                drop    <= 1'b0;
                overrun <= 1'b1;
                if (frames_dropped != 16'hFFFF)
                    frames_dropped <= frames_dropped + 16'd1;
            end else if (do_write) begin
                wr_ptr  <= wr_ptr + ptr_t'(1);
                cur_len <= cur_len + 16'd1;
            end else if (set_drop) begin
                drop <= 1'b1;
            end
        end
    end

    // The output register doubles as the RAM read register: the first byte is read
    // straight out of IDLE and each handshake reads ahead the following byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            lf_rd       <= '0;
            rd_left     <= '0;
            out_data    <= '0;
            out_sof     <= 1'b0;
            out_eof     <= 1'b0;
            out_src_rdy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!lf_empty) begin
                        rd_left     <= len_ram[lf_rd[LWIDTH-1:0]];
                        lf_rd       <= lf_rd + lptr_t'(1);
                        out_data    <= data_ram[rd_ptr[AWIDTH-1:0]];
                        out_sof     <= 1'b1;
                        out_eof     <= len_ram[lf_rd[LWIDTH-1:0]] == 16'd1;
                        out_src_rdy <= 1'b1;
                        state       <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_dst_rdy) begin
                        rd_ptr  <= rd_next;
                        rd_left <= rd_left - 16'd1;
                        out_sof <= 1'b0;
                        if (out_eof) begin
                            out_eof     <= 1'b0;
                            out_src_rdy <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            out_data <= data_ram[rd_next[AWIDTH-1:0]];
                            out_eof  <= rd_left == 16'd2;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
